vga_text_cursor_ctrl: RTL and testbench

//  Sequences the keyboard/calculator write stream into the VGA text-mode character RAM.

---
 rtl/vga_text_cursor_ctrl.sv | 178 +++++++++++++++++
 tb/tb_vga_text_cursor_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_cursor_ctrl.sv
// VGA text-mode write sequencer: input register, command FIFO, cursor tracking, char-RAM writes.
// Define VGA_ROW_CLEAR_EN to blank every newly entered row (CLEAR state).
module vga_text_cursor_ctrl #(
   parameter int COLS       = 80,
   parameter int ROWS       = 30,
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [1:0]        COMMAND,
   input  logic [7:0]        ASCII_IN,
   input  logic [7:0]        COLOR_IN,
   input  logic              RAM_RD_BUSY,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [15:0]       RAM_WDATA,
   output logic [4:0]        CUR_ROW,
   output logic [6:0]        CUR_COL,
   output logic              BUSY,
   output logic              OVERFLOW
);
   localparam int          PW       = $clog2(FIFO_DEPTH);
   localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
   localparam logic [15:0] BLANK    = 16'hFF20;

`ifdef VGA_ROW_CLEAR_EN
   typedef enum logic [1:0] { S_IDLE, S_EXEC, S_CLEAR } state_t;
`else
   typedef enum logic [1:0] { S_IDLE, S_EXEC } state_t;
`endif

   state_t            state_q;
   logic              in_vld_q;
   logic [17:0]       in_q;
   logic [17:0]       mem_q [FIFO_DEPTH];
   logic [PW:0]       wr_ptr_q, rd_ptr_q;
   logic              fifo_empty, fifo_full, pop, push;
   logic              ovf_q;
   logic [17:0]       hold_q;
   logic [1:0]        h_cmd;
   logic [4:0]        row_q, row_nxt;
   logic [6:0]        col_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
`ifdef VGA_ROW_CLEAR_EN
   logic [6:0]        clr_col_q;
   logic              row_adv;
`endif

   function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] r, input logic [6:0] c);
      return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
   endfunction

   // Input register stage so a command reaches the FIFO one edge after it is presented.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         in_vld_q <= 1'b0;
         in_q     <= '0;
      end else begin
         in_vld_q <= (COMMAND != 2'b11);
         in_q     <= {COMMAND, COLOR_IN, ASCII_IN};
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop        = (state_q == S_IDLE) && !fifo_empty;
   assign push       = in_vld_q && (!fifo_full || pop);

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q[PW-1:0]] <= in_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         ovf_q <= in_vld_q && fifo_full && !pop;
      end
   end

   assign h_cmd   = hold_q[17:16];
   assign row_nxt = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
`ifdef VGA_ROW_CLEAR_EN
   assign row_adv = (h_cmd == 2'b10) || (h_cmd == 2'b00 && col_q == LAST_COL);
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef VGA_ROW_CLEAR_EN
         clr_col_q <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         case (state_q)
            S_IDLE: if (!fifo_empty) begin
               hold_q  <= mem_q[rd_ptr_q[PW-1:0]];
               state_q <= S_EXEC;
            end
            S_EXEC: if (!RAM_RD_BUSY) begin
               state_q <= S_IDLE;
               case (h_cmd)
                  2'b00: begin
                     we_q    <= 1'b1;
                     addr_q  <= addr_of(row_q, col_q);
                     wdata_q <= hold_q[15:0];
                     if (col_q == LAST_COL) begin
                        col_q <= '0;
                        row_q <= row_nxt;
                     end else begin
                        col_q <= col_q + 7'd1;
                     end
                  end
                  2'b01: begin
                     // Backspace: step back (wrapping to previous row), then blank that cell.
                     if (col_q != 7'd0) begin
                        col_q   <= col_q - 7'd1;
                        we_q    <= 1'b1;
                        addr_q  <= addr_of(row_q, col_q - 7'd1);
                        wdata_q <= BLANK;
                     end else if (row_q != 5'd0) begin
                        row_q   <= row_q - 5'd1;
                        col_q   <= LAST_COL;
                        we_q    <= 1'b1;
                        addr_q  <= addr_of(row_q - 5'd1, LAST_COL);
                        wdata_q <= BLANK;
                     end
                  end
                  2'b10: begin
                     col_q <= '0;
                     row_q <= row_nxt;
                  end
                  default: ;
               endcase
`ifdef VGA_ROW_CLEAR_EN
               if (row_adv) begin
                  state_q   <= S_CLEAR;
                  clr_col_q <= '0;
               end
`endif
            end
`ifdef VGA_ROW_CLEAR_EN
            S_CLEAR: if (!RAM_RD_BUSY) begin
               we_q    <= 1'b1;
               addr_q  <= addr_of(row_q, clr_col_q);
               wdata_q <= BLANK;
               if (clr_col_q == LAST_COL) state_q <= S_IDLE;
               else clr_col_q <= clr_col_q + 7'd1;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign RAM_WE    = we_q;
   assign RAM_ADDR  = addr_q;
   assign RAM_WDATA = wdata_q;
   assign CUR_ROW   = row_q;
   assign CUR_COL   = col_q;
   assign BUSY      = !fifo_empty || (state_q != S_IDLE);
   assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_vga_text_cursor_ctrl.sv
// Directed bench for vga_text_cursor_ctrl: latency, cursor wrap, delete, stalls, overflow, row clear.
module tb_vga_text_cursor_ctrl;
   localparam int ADDR_W = 12;
`ifdef VGA_ROW_CLEAR_EN
   localparam int CLR_W = 80;
`else
   localparam int CLR_W = 0;
`endif

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic [1:0]        COMMAND = 2'b11;
   logic [7:0]        ASCII_IN = 8'h00;
   logic [7:0]        COLOR_IN = 8'h00;
   logic              RAM_RD_BUSY = 1'b0;
   logic              RAM_WE;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic [15:0]       RAM_WDATA;
   logic [4:0]        CUR_ROW;
   logic [6:0]        CUR_COL;
   logic              BUSY;
   logic              OVERFLOW;

   vga_text_cursor_ctrl #(.COLS(80), .ROWS(30), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .COMMAND(COMMAND), .ASCII_IN(ASCII_IN), .COLOR_IN(COLOR_IN),
      .RAM_RD_BUSY(RAM_RD_BUSY), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
      .CUR_ROW(CUR_ROW), .CUR_COL(CUR_COL), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_pass = 0;
   int ovf_cnt = 0, viol = 0;
   logic [ADDR_W-1:0] wa[$];
   logic [15:0]       wd[$];

   // Write/overflow monitor, sampled 2 time units after the rising edge.
   always @(posedge CLK) begin
      #2;
      if (RAM_WE) begin
         wa.push_back(RAM_ADDR);
         wd.push_back(RAM_WDATA);
         if (RAM_RD_BUSY) viol++;
      end
      if (OVERFLOW) ovf_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge CLK);
      while (BUSY && n < 500) begin
         @(negedge CLK);
         n++;
      end
      if (BUSY) chk("drain_timeout", 32'(BUSY), 0);
      @(negedge CLK);
   endtask

   task automatic send(input logic [1:0] c, input logic [7:0] a, input logic [7:0] col);
      @(negedge CLK);
      COMMAND = c; ASCII_IN = a; COLOR_IN = col;
      @(negedge CLK);
      COMMAND = 2'b11;
      drain();
   endtask

   task automatic newlines(input int n);
      for (int i = 0; i < n; i++) send(2'b10, 8'h00, 8'h00);
   endtask

   task automatic chars(input int n);
      for (int i = 0; i < n; i++) send(2'b00, 8'h61 + 8'(i % 26), 8'h0F);
   endtask

   initial begin
      int idx;
      int first;
      #12;
      chk("rst_we", 32'(RAM_WE), 0);
      chk("rst_addr", 32'(RAM_ADDR), 0);
      chk("rst_row", 32'(CUR_ROW), 0);
      chk("rst_col", 32'(CUR_COL), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_ovf", 32'(OVERFLOW), 0);
      @(negedge CLK);
      RST_N = 1'b1;

      // T1: exact latency of first display write
      @(negedge CLK);
      COMMAND = 2'b00; ASCII_IN = 8'h41; COLOR_IN = 8'h1C;
      for (int k = 0; k <= 3; k++) begin
         @(negedge CLK);
         if (k == 0) COMMAND = 2'b11;
         if (k == 2) chk("t1_we_e2", 32'(RAM_WE), 0);
         if (k == 3) begin
            chk("t1_we_e3", 32'(RAM_WE), 1);
            chk("t1_addr", 32'(RAM_ADDR), 0);
            chk("t1_wdata", 32'(RAM_WDATA), 32'h1C41);
            chk("t1_col", 32'(CUR_COL), 1);
            chk("t1_row", 32'(CUR_ROW), 0);
         end
      end
      drain();

      // T2: end-of-row wrap, then newline wrapping past the last row
      chars(78);
      chk("t2_col79", 32'(CUR_COL), 79);
      idx = wa.size();
      send(2'b00, 8'h42, 8'h07);
      chk("t2_addr", 32'(wa[idx]), 79);
      chk("t2_wdata", 32'(wd[idx]), 32'h0742);
      chk("t2_nwr", wa.size() - idx, 1 + CLR_W);
      chk("t2_row", 32'(CUR_ROW), 1);
      chk("t2_col", 32'(CUR_COL), 0);
      newlines(28);
      chars(5);
      chk("t2_row29", 32'(CUR_ROW), 29);
      chk("t2_col5", 32'(CUR_COL), 5);
      idx = wa.size();
      send(2'b10, 8'h00, 8'h00);
      chk("t2_nl_nwr", wa.size() - idx, CLR_W);
      chk("t2_nl_row", 32'(CUR_ROW), 0);
      chk("t2_nl_col", 32'(CUR_COL), 0);

      // T3: delete across a row boundary, at home, and within a row
      newlines(2);
      idx = wa.size();
      send(2'b01, 8'h00, 8'h00);
      chk("t3_nwr", wa.size() - idx, 1);
      chk("t3_addr", 32'(wa[idx]), 159);
      chk("t3_wdata", 32'(wd[idx]), 32'hFF20);
      chk("t3_row", 32'(CUR_ROW), 1);
      chk("t3_col", 32'(CUR_COL), 79);
      newlines(29);
      chk("t3_home_row", 32'(CUR_ROW), 0);
      idx = wa.size();
      send(2'b01, 8'h00, 8'h00);
      chk("t3_home_nwr", wa.size() - idx, 0);
      chk("t3_home_row2", 32'(CUR_ROW), 0);
      chk("t3_home_col", 32'(CUR_COL), 0);
      send(2'b00, 8'h78, 8'h01);
      idx = wa.size();
      send(2'b01, 8'h00, 8'h00);
      chk("t3_del_addr", 32'(wa[idx]), 0);
      chk("t3_del_wdata", 32'(wd[idx]), 32'hFF20);
      chk("t3_del_col", 32'(CUR_COL), 0);

      // T4: five stall cycles in EXEC push the write from edge 3 to edge 8
      idx = wa.size();
      first = -1;
      @(negedge CLK);
      COMMAND = 2'b00; ASCII_IN = 8'h5A; COLOR_IN = 8'h03; RAM_RD_BUSY = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (k == 0) COMMAND = 2'b11;
         if (RAM_WE && first < 0) first = k;
         if (k == 7) RAM_RD_BUSY = 1'b0;
      end
      chk("t4_first_we", first, 8);
      chk("t4_nwr", wa.size() - idx, 1);
      chk("t4_wdata", 32'(wd[idx]), 32'h035A);
      chk("t4_col", 32'(CUR_COL), 1);
      drain();

      // T5: six back-to-back pushes while stalled; the sixth is dropped
      idx = wa.size();
      ovf_cnt = 0;
      RAM_RD_BUSY = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         COMMAND = 2'b00; ASCII_IN = 8'h61 + 8'(i); COLOR_IN = 8'h10 + 8'(i);
      end
      @(negedge CLK);
      COMMAND = 2'b11;
      repeat (4) @(negedge CLK);
      chk("t5_ovf", ovf_cnt, 1);
      chk("t5_busy", 32'(BUSY), 1);
      chk("t5_nwr_stall", wa.size() - idx, 0);
      RAM_RD_BUSY = 1'b0;
      drain();
      chk("t5_nwr", wa.size() - idx, 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t5_addr%0d", i), 32'(wa[idx + i]), 32'(1 + i));
         chk($sformatf("t5_wdata%0d", i), 32'(wd[idx + i]), {16'h0, 8'h10 + 8'(i), 8'h61 + 8'(i)});
      end
      chk("t5_col", 32'(CUR_COL), 6);
      chk("we_while_busy", viol, 0);

`ifdef VGA_ROW_CLEAR_EN
      // T6: newline at (3,7) blanks row 4; reset during a later clear
      begin
         int lowb = 0;
         int n = 0;
         newlines(3);
         chars(7);
         idx = wa.size();
         @(negedge CLK);
         COMMAND = 2'b10;
         @(negedge CLK);
         COMMAND = 2'b11;
         @(negedge CLK);
         while (wa.size() < idx + 80 && n < 300) begin
            if (!BUSY) lowb++;
            @(negedge CLK);
            n++;
         end
         drain();
         chk("t6_nwr", wa.size() - idx, 80);
         chk("t6_first", 32'(wa[idx]), 320);
         chk("t6_last", 32'(wa[idx + 79]), 399);
         chk("t6_blank", 32'(wd[idx + 40]), 32'hFF20);
         chk("t6_busy_low", lowb, 0);
         @(negedge CLK);
         COMMAND = 2'b10;
         @(negedge CLK);
         COMMAND = 2'b11;
         repeat (15) @(negedge CLK);
         RST_N = 1'b0;
         #1;
         chk("t6_rst_we", 32'(RAM_WE), 0);
         chk("t6_rst_row", 32'(CUR_ROW), 0);
         chk("t6_rst_col", 32'(CUR_COL), 0);
         @(negedge CLK);
         RST_N = 1'b1;
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
